// File: rtl/arith_pkg.sv
// Shared widths and state encoding for the iterative arithmetic units.
package arith_pkg;

    localparam int CBRT_IN_W  = 16;
    localparam int CBRT_OUT_W = 6;
    localparam int MUL_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WAIT = 2'd2
    } cbrt_state_t;

endpackage

// File: rtl/mul8.sv
// 8x8 -> 16 unsigned shift-add multiplier, one partial product per cycle.
// Busy is high for exactly 8 cycles after the accepting edge, and the
// product is held until the next start.
module mul8
    import arith_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [MUL_W-1:0]       a_bi,
    input  logic [MUL_W-1:0]       b_bi,
    output logic                   busy_o,
    output logic [2*MUL_W-1:0]     y_bo
);

    logic [2*MUL_W-1:0] mcand;
    logic [MUL_W-1:0]   mplier;
    logic [3:0]         cnt;

    // Accept a new operand pair while idle, then add one shifted partial product per cycle.
    // cnt counts down the remaining steps; the last step drops busy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy_o <= 1'b0;
            y_bo   <= '0;
        end else if (!busy_o) begin
            if (start_i) begin
                mcand  <= {{MUL_W{1'b0}}, a_bi};
                mplier <= b_bi;
                cnt    <= 4'd8;
                busy_o <= 1'b1;
                y_bo   <= '0;
            end
        end else begin
            if (mplier[0]) begin
                y_bo <= y_bo + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cbrt_unit.sv
// Iterative 16-bit unsigned cube root, y = floor(x^(1/3)), one result bit
// per iteration using the shared sequential multiplier.
//
// state | meaning
// IDLE  | waiting for start_i; y_bo holds last result
// MUL   | launch multiplier with (2y)*(2y+1), double y
// WAIT  | wait for product, then trial-subtract 3p+1 at shift s
module cbrt_unit
    import arith_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [CBRT_IN_W-1:0]   x_bi,
    output logic                   busy_o,
    output logic [CBRT_OUT_W-1:0]  y_bo
);

    cbrt_state_t            state;
    logic [CBRT_IN_W-1:0]   x;
    logic [CBRT_OUT_W-1:0]  y;
    logic [3:0]             s;

    logic                   mul_start;
    logic [MUL_W-1:0]       mul_a;
    logic [MUL_W-1:0]       mul_b;
    logic                   mul_busy;
    logic [2*MUL_W-1:0]     mul_p;

    logic [12:0]            t;
    logic [CBRT_IN_W-1:0]   x_shift;
    logic                   fits;
    logic [CBRT_IN_W-1:0]   x_sub;
    logic [CBRT_OUT_W-1:0]  y_next;

    assign mul_start = (state == MUL);
    assign mul_a     = {1'b0, y, 1'b0};
    assign mul_b     = {1'b0, y, 1'b1};

    mul8 u_mul8 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_bi    (mul_a),
        .b_bi    (mul_b),
        .busy_o  (mul_busy),
        .y_bo    (mul_p)
    );

    // Trial step: (2y+1)^3 - (2y)^3 = 3*(2y)*(2y+1) + 1. Comparing the shifted
    // remainder instead of t<<s keeps everything inside 16 bits.
    always_comb begin
        t       = 13'(mul_p * 16'd3 + 16'd1);
        x_shift = x >> s;
        fits    = (x_shift >= {3'b000, t});
        x_sub   = x - ({3'b000, t} << s);
        y_next  = fits ? (y + 6'd1) : y;
    end

    assign busy_o = (state != IDLE);

    // Sequencer: six iterations at s = 15, 12, 9, 6, 3, 0; result published only on completion.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            s     <= '0;
            y_bo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x     <= x_bi;
                        y     <= '0;
                        s     <= 4'd15;
                        state <= MUL;
                    end
                end
                MUL: begin
                    y     <= {y[CBRT_OUT_W-2:0], 1'b0};
                    state <= WAIT;
                end
                WAIT: begin
                    if (!mul_busy) begin
                        if (fits) begin
                            x <= x_sub;
                        end
                        y <= y_next;
                        if (s == 4'd0) begin
                            y_bo  <= y_next;
                            state <= IDLE;
                        end else begin
                            s     <= s - 4'd3;
                            state <= MUL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbrt_unit.sv
// Scoreboard bench for cbrt_unit: driver pushes the reference cube root on
// each accepted start, monitor pops and compares when busy_o falls.
module tb_cbrt_unit;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] x_bi    = '0;
    logic        busy_o;
    logic [5:0]  y_bo;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    cbrt_unit dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .x_bi    (x_bi),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    always #5 clk_i = ~clk_i;

    // Reference: largest r with r^3 <= x.
    function automatic int cbrt_ref(input int xv);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= xv) r++;
        return r;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Monitor: latency, result and hold-while-busy checks.
    initial begin
        int run = 0;
        int last_y = 0;
        int e;
        logic prev_busy = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                exp_q.delete();
                prev_busy = 1'b0;
                run = 0;
                last_y = 0;
            end else begin
                if (busy_o) begin
                    run++;
                    check("hold_while_busy", int'(y_bo), last_y);
                end else if (prev_busy) begin
                    check("latency", run, 60);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=%0d required=none", y_bo);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", int'(y_bo), e);
                        last_y = e;
                    end
                    run = 0;
                end
                prev_busy = busy_o;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input logic [15:0] xv);
        wait_idle();
        x_bi    = xv;
        start_i = 1'b1;
        exp_q.push_back(cbrt_ref(int'(xv)));
        @(negedge clk_i);
        start_i = 1'b0;
        x_bi    = 16'($urandom);
        check("accepted", int'(busy_o), 1);
    endtask

    initial begin
        logic [15:0] bounds [6] = '{16'd27, 16'd0, 16'd1, 16'd63999, 16'd64000, 16'd65535};

        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_busy", int'(busy_o), 0);
        check("reset_y", int'(y_bo), 0);
        rst_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("idle_busy", int'(busy_o), 0);
            check("idle_y", int'(y_bo), 0);
        end

        foreach (bounds[i]) begin
            issue(bounds[i]);
        end

        // Busy interlock: a second start mid-computation must be ignored.
        issue(16'd1000);
        repeat (18) @(negedge clk_i);
        x_bi    = 16'd8;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;

        // Back-to-back: issued on the first idle cycle.
        issue(16'd125);

        for (int k = 0; k < 25; k++) begin
            logic [15:0] v;
            int gap;
            v   = (k % 5 == 0) ? 16'($urandom_range(1, 40) ** 3 - (k % 2)) : 16'($urandom);
            gap = $urandom_range(0, 3);
            wait_idle();
            repeat (gap) @(negedge clk_i);
            issue(v);
        end

        // Mid-operation asynchronous reset.
        issue(16'd50000);
        repeat (28) @(negedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check("async_reset_busy", int'(busy_o), 0);
        check("async_reset_y", int'(y_bo), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        issue(16'd8);

        wait_idle();
        @(negedge clk_i);
        check("pending_results", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbrt_unit.md
# cbrt_unit

Iterative 16-bit unsigned integer cube root: y = floor(x^(1/3)), result 0..40. It is a responder on the lab's start/busy handshake, the same contract the function top-level uses to drive its arithmetic units. It performs the inverse of the cube unit and can be dropped in wherever a start/busy arithmetic block is expected. It computes one result bit per iteration, using a shared sequential multiplier.

## Interface
- none; widths are fixed, see constants in Structure
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-low reset (0 = reset)
- start_i  in  1  request; sampled only while idle
- x_bi  in  16  unsigned operand; sampled on the accepting edge only
- busy_o  out  1  high while a computation is in progress
- y_bo  out  6  result; holds the last completed value

## Operation
- Reset (rst_i low, any time, including mid-operation):
  - busy_o=0, y_bo=0, FSM to IDLE.
  - Multiplier aborted and idle; internal x/y/s cleared.
- FSM states: IDLE, MUL, WAIT; busy_o = (state != IDLE).
- IDLE, on start_i=1:
  - Latch x<=x_bi, y<=0, s<=15.
  - Go to MUL.
  - Otherwise stay in IDLE.
- MUL (one cycle):
  - Drive mul start=1 with operands a=2y, b=2y+1 (zero-extended to 8 bits).
  - Set y<=2y.
  - Go to WAIT.
- WAIT: stay while mul busy=1. On the first cycle with mul busy=0:
  - Compute t = 3*p + 1, where p is the multiplier product. Max t is 4921, held in 13 bits; no overflow.
  - If (x >> s) >= t: x <= x - (t << s) and y <= y+1.
  - If s==0: y_bo <= final y, then go to IDLE.
  - Else: s <= s-3, then go to MUL.
- Iterations run for s = 15, 12, 9, 6, 3, 0 (six iterations).
- Intermediate widths:
  - y ≤ 20 before its final doubling, so multiplier operands ≤ 41.
  - Compare the shifted x, not t<<s, so no 16-bit overflow can occur.
- start_i while busy is ignored; there is no queueing.
- x_bi changes after acceptance have no effect.
- y_bo changes only on the completion edge and never shows partial values.

## Timing
- Acceptance edge E0 (IDLE, start_i=1); busy_o is high from cycle 1 through cycle 60.
- Each iteration takes 10 cycles: MUL (1) + multiplier busy (8) + WAIT exit cycle (1).
- At edge E60: y_bo is updated and the FSM returns to IDLE. busy_o=0 in cycle 61.
- Fixed latency of 60 cycles, independent of x.
- Back-to-back operation: start_i=1 in cycle 61 is accepted at E61.
- Multiplier contract (mul8):
  - Samples start on an edge while idle.
  - busy high for exactly the 8 following cycles.
  - Product is valid and held from the first busy-low cycle until its next start.

## Structure
- Package arith_pkg holds:
  - CBRT_IN_W=16, CBRT_OUT_W=6, MUL_W=8
  - The cbrt FSM state enum (IDLE/MUL/WAIT)
- Sub-module mul8: 8x8 -> 16 unsigned shift-add multiplier.
  - Ports: clk_i, rst_i (same async active-low reset), start_i, a_bi, b_bi, busy_o, y_bo.
  - One partial product per cycle, 8 cycles.
- The mul8 instance is owned by cbrt_unit. Its start is driven combinationally from state==MUL.

## Test plan
- Reset: hold rst_i=0, then release -> busy_o=0, y_bo=0. With no start_i, state is unchanged.
- Basic: x_bi=27, start_i pulse -> busy_o high for exactly 60 cycles, y_bo=3 in cycle 61.
- Boundaries, each checked for exactly 60-cycle latency:
  - x_bi=0 -> 0
  - x_bi=1 -> 1
  - x_bi=63999 -> 39
  - x_bi=64000 -> 40
  - x_bi=65535 -> 40
- Busy interlock: start x_bi=1000, then pulse start_i with x_bi=8 at cycle 20 -> ignored; y_bo=10 at cycle 61.
- Back-to-back: second start (x_bi=125) asserted in cycle 61 -> accepted at E61; y_bo=5 after a further 60 cycles; y_bo holds the first result until then.
- Mid-operation reset: drive rst_i=0 asynchronously at cycle 30 -> busy_o and y_bo drop to 0 immediately. A new start after release (x_bi=8) -> y_bo=2, 60 cycles.
